// File: rtl/dma_pkg.sv
// Shared types and constants for the 8237-style DMA timing-and-control block.
package dma_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned FIELD_W = 2;

  // Command register bit positions
  localparam int unsigned CMD_CTRL_DISABLE_BIT = 2;
  localparam int unsigned CMD_ROT_PRIO_BIT     = 4;
  localparam int unsigned CMD_DREQ_LOW_BIT     = 6;
  localparam int unsigned CMD_DACK_HIGH_BIT    = 7;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} dmaState_t;

  typedef enum logic [1:0] {
    VERIFY = 2'b00,
    WRITE  = 2'b01,
    READ   = 2'b10
  } xferType_t;

  typedef enum logic [1:0] {
    DEMAND  = 2'b00,
    SINGLE  = 2'b01,
    BLOCK   = 2'b10,
    CASCADE = 2'b11
  } modeSel_t;

  // Extract a channel's 2-bit field from a packed per-channel mode vector
  function automatic logic [FIELD_W-1:0] ch_field(input logic [NUM_CH*FIELD_W-1:0] v,
                                                  input logic [CH_W-1:0] ch);
    return v[{ch, 1'b0} +: FIELD_W];
  endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// Fixed/rotating priority arbiter; owns the rotation pointer (highest-priority channel).
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              rotating,
  input  logic              update,
  input  logic [CH_W-1:0]   served,
  output logic [CH_W-1:0]   grant,
  output logic              valid
);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] base;
  logic [CH_W-1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is kept
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    base  = rotating ? ptr : '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = base + CH_W'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

  // The channel just serviced drops to lowest priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= served + CH_W'(1);
    end
  end

endmodule

// File: rtl/dma_timing_control.sv
// DMA timing-and-control sequencer: request arbitration, HRQ/HLDA handshake and
// the S1-S4 transfer sequence driving DACK, AEN, ADSTB, bus strobes and EOP.
module dma_timing_control
  import dma_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic                      HLDA,
  input  logic                      EOP_N_in,
  input  logic                      cmdCtrlDisable,
  input  logic                      cmdRotatingPriority,
  input  logic                      cmdDreqActiveLow,
  input  logic                      cmdDackActiveHigh,
  input  logic [NUM_CH-1:0]         maskReg,
  input  logic [NUM_CH*FIELD_W-1:0] modeXfer,
  input  logic [NUM_CH*FIELD_W-1:0] modeSel,
  input  logic                      tcReached,
  input  logic                      readStatusClear,
  output logic                      HRQ,
  output logic [NUM_CH-1:0]         DACK,
  output logic                      AEN,
  output logic                      ADSTB,
  output logic                      MEMR_N,
  output logic                      MEMW_N,
  output logic                      IOR_N,
  output logic                      IOW_N,
  output logic                      EOP_N_out,
  output logic                      addrWordUpdate,
  output logic [CH_W-1:0]           activeChannel,
  output logic [NUM_CH-1:0]         tcStatus
);

  dmaState_t           state, state_nxt;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   tc_set;
  logic [NUM_CH-1:0]   dack_act;
  logic [CH_W-1:0]     grant;
  logic [CH_W-1:0]     ch_nxt;
  logic                gnt_valid;
  logic                eop_seen;
  logic                terminal;
  logic                svc_exit;
  logic                data_nxt;
  logic                late_nxt;
  modeSel_t            mode;
  logic [FIELD_W-1:0]  xfer;

  assign req      = (DREQ ^ {NUM_CH{cmdDreqActiveLow}}) & ~maskReg;
  assign mode     = modeSel_t'(ch_field(modeSel, activeChannel));
  assign xfer     = ch_field(modeXfer, ch_nxt);
  // EOP_N_out low in S4 already records tcReached seen on S4 entry
  assign terminal = ~EOP_N_out | tcReached | eop_seen | ~EOP_N_in;

  dma_priority_arbiter u_arb (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .req      (req),
    .rotating (cmdRotatingPriority),
    .update   (svc_exit),
    .served   (activeChannel),
    .grant    (grant),
    .valid    (gnt_valid)
  );

  // Next-state and per-transfer decisions
  always_comb begin
    state_nxt = state;
    tc_set    = '0;
    case (state)
      SI: if (gnt_valid && !cmdCtrlDisable) state_nxt = S0;
      S0: begin
        if (!gnt_valid) state_nxt = SI;
        else if (HLDA)  state_nxt = S1;
      end
      S1: state_nxt = HLDA ? S2 : SI;
      S2: state_nxt = HLDA ? S3 : SI;
      S3: state_nxt = HLDA ? S4 : SI;
      S4: begin
        if (terminal) tc_set[activeChannel] = 1'b1;
        if (!HLDA || terminal) begin
          state_nxt = SI;
        end else begin
          case (mode)
            BLOCK:   state_nxt = (!maskReg[activeChannel] && !cmdCtrlDisable) ? S1 : SI;
            DEMAND:  state_nxt = (req[activeChannel] && !cmdCtrlDisable) ? S1 : SI;
            default: state_nxt = SI;
          endcase
        end
      end
      default: state_nxt = SI;
    endcase
  end

  assign svc_exit = (state inside {S1, S2, S3, S4}) && (state_nxt == SI);
  assign ch_nxt   = (state == S0 && state_nxt == S1) ? grant : activeChannel;
  assign data_nxt = state_nxt inside {S2, S3, S4};
  assign late_nxt = state_nxt inside {S3, S4};

  // State register with outputs decoded from the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= SI;
      HRQ            <= 1'b0;
      AEN            <= 1'b0;
      ADSTB          <= 1'b0;
      MEMR_N         <= 1'b1;
      MEMW_N         <= 1'b1;
      IOR_N          <= 1'b1;
      IOW_N          <= 1'b1;
      EOP_N_out      <= 1'b1;
      addrWordUpdate <= 1'b0;
      activeChannel  <= '0;
      dack_act       <= '0;
      tcStatus       <= '0;
      eop_seen       <= 1'b0;
    end else begin
      state          <= state_nxt;
      activeChannel  <= ch_nxt;
      HRQ            <= (state_nxt != SI);
      AEN            <= (state_nxt inside {S1, S2, S3, S4});
      ADSTB          <= (state_nxt == S1);
      dack_act       <= data_nxt ? (NUM_CH'(1) << ch_nxt) : '0;
      MEMR_N         <= !(data_nxt && xfer == FIELD_W'(READ));
      IOW_N          <= !(late_nxt && xfer == FIELD_W'(READ));
      IOR_N          <= !(data_nxt && xfer == FIELD_W'(WRITE));
      MEMW_N         <= !(late_nxt && xfer == FIELD_W'(WRITE));
      addrWordUpdate <= (state_nxt == S4);
      EOP_N_out      <= !(state_nxt == S4 && tcReached);
      tcStatus       <= (readStatusClear ? '0 : tcStatus) | tc_set;
      eop_seen       <= (state inside {S2, S3}) && (eop_seen || !EOP_N_in);
    end
  end

  assign DACK = cmdDackActiveHigh ? dack_act : ~dack_act;

endmodule

// File: tb/tb_dma_timing_control.sv
// Bench for dma_timing_control: directed scenarios plus randomized services,
// checked against a transaction-level model of arbitration and bus phases.
module tb_dma_timing_control;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] DREQ = '0;
  logic       HLDA = 1'b0;
  logic       EOP_N_in = 1'b1;
  logic       cmdCtrlDisable = 1'b0;
  logic       cmdRotatingPriority = 1'b0;
  logic       cmdDreqActiveLow = 1'b0;
  logic       cmdDackActiveHigh = 1'b0;
  logic [3:0] maskReg = '0;
  logic [7:0] modeXfer = '0;
  logic [7:0] modeSel = 8'b01_01_01_01;
  logic       tcReached = 1'b0;
  logic       readStatusClear = 1'b0;
  logic       HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, addrWordUpdate;
  logic [3:0] DACK, tcStatus;
  logic [1:0] activeChannel;

  int errors = 0;
  int checks = 0;

  // Model state: rotation pointer (highest priority) and sticky TC bits
  int         ptr_m = 0;
  logic [3:0] tc_m = '0;

  dma_timing_control dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N_in(EOP_N_in),
    .cmdCtrlDisable(cmdCtrlDisable), .cmdRotatingPriority(cmdRotatingPriority),
    .cmdDreqActiveLow(cmdDreqActiveLow), .cmdDackActiveHigh(cmdDackActiveHigh),
    .maskReg(maskReg), .modeXfer(modeXfer), .modeSel(modeSel), .tcReached(tcReached),
    .readStatusClear(readStatusClear), .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
    .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N_out(EOP_N_out),
    .addrWordUpdate(addrWordUpdate), .activeChannel(activeChannel), .tcStatus(tcStatus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input bit rot);
    int base = rot ? ptr_m : 0;
    for (int i = 0; i < 4; i++)
      if (r[(base + i) % 4]) return (base + i) % 4;
    return 0;
  endfunction

  // Expected bus outputs for phase 0 (idle) or S1..S4 (phase 1..4)
  function automatic logic [14:0] bus_exp(input int phase, input int ch, input int xf,
                                          input bit tc, input bit dhi);
    logic [3:0] one = 4'b0001;
    logic [3:0] on;
    logic [1:0] chv = 2'(ch);
    on = (phase >= 2) ? (one << ch) : 4'b0000;
    return {phase > 0, phase > 0, phase == 1,
            !(xf == 2 && phase >= 2), !(xf == 1 && phase >= 3),
            !(xf == 1 && phase >= 2), !(xf == 2 && phase >= 3),
            phase == 4, !(phase == 4 && tc),
            dhi ? on : ~on, chv};
  endfunction

  function automatic logic [14:0] bus_now();
    return {HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, addrWordUpdate, EOP_N_out,
            DACK, activeChannel};
  endfunction

  task automatic set_req(input logic [3:0] r);
    DREQ = r ^ {4{cmdDreqActiveLow}};
  endtask

  // Expect HRQ one cycle after the request, then return HLDA after 'delay' cycles
  task automatic grant_bus(input int delay);
    int waited = 0;
    @(negedge CLK);
    while (!HRQ && waited < 10) begin
      waited++;
      @(negedge CLK);
    end
    check("hrq_latency", waited, 0);
    check("aen_before_hlda", AEN, 0);
    repeat (delay) @(negedge CLK);
    HLDA = 1'b1;
  endtask

  // Observe n words on channel ch, then the idle cycle; act: 1 drop DREQ, 2 mask ch,
  // 3 disable, 4 status read on exit, 5 external EOP
  task automatic run_xfer(input int ch, input int n, input int tc_word,
                          input int act_word, input int act, input bit term);
    int xf = int'(modeXfer[2*ch +: 2]);
    bit rsc = (act == 4 && act_word == n);
    logic [3:0] one = 4'b0001;
    for (int w = 1; w <= n; w++) begin
      for (int p = 1; p <= 4; p++) begin
        @(negedge CLK);
        check($sformatf("ch%0d_w%0d_s%0d", ch, w, p), bus_now(),
              bus_exp(p, ch, xf, w == tc_word, cmdDackActiveHigh));
        if (p == 1) tcReached = (w == tc_word);
        if (p == 4) tcReached = 1'b0;
        if (w == act_word && p == 2) begin
          case (act)
            1: set_req(4'b0000);
            2: maskReg = maskReg | (one << ch);
            3: cmdCtrlDisable = 1'b1;
            5: EOP_N_in = 1'b0;
            default: ;
          endcase
        end
        if (w == act_word && p == 4) begin
          if (act == 4) readStatusClear = 1'b1;
          if (act == 5) EOP_N_in = 1'b1;
        end
      end
    end
    ptr_m = (ch + 1) % 4;
    tc_m  = (rsc ? 4'b0000 : tc_m) | (term ? (one << ch) : 4'b0000);
    @(negedge CLK);
    check($sformatf("ch%0d_idle", ch), bus_now(), bus_exp(0, ch, xf, 0, cmdDackActiveHigh));
    check($sformatf("ch%0d_tcstatus", ch), tcStatus, tc_m);
    HLDA = 1'b0;
    readStatusClear = 1'b0;
  endtask

  task automatic idle_watch(input int n, input string tag);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      seen = seen | HRQ;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int ch, n, md, tcw;
    logic [3:0] r, m;

    // Reset values, DACK polarity follows the command bit even in reset
    repeat (2) @(negedge CLK);
    check("reset_bus", bus_now(), bus_exp(0, 0, 0, 0, 0));
    check("reset_tc", tcStatus, 0);
    cmdDackActiveHigh = 1'b1;
    #1 check("reset_dack_hi", DACK, 4'b0000);
    cmdDackActiveHigh = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    idle_watch(2, "idle_no_req");

    // Rotating priority, ch0 and ch2 in single mode
    cmdRotatingPriority = 1'b1;
    modeXfer = 8'b00_01_00_10;
    set_req(4'b0101);
    for (int k = 0; k < 3; k++) begin
      ch = pick(4'b0101, 1'b1);
      grant_bus(1);
      run_xfer(ch, 1, 0, 0, 0, 0);
    end
    set_req(4'b0000);

    // Fixed priority, DREQ=1010, HLDA two cycles after HRQ
    cmdRotatingPriority = 1'b0;
    modeXfer = 8'b00_00_10_00;
    set_req(4'b1010);
    grant_bus(2);
    run_xfer(pick(4'b1010, 1'b0), 1, 0, 0, 0, 0);
    set_req(4'b0000);

    // Block read on ch3, terminal count on the 3rd word
    modeSel = 8'b10_01_01_01;
    modeXfer = 8'b10_00_00_00;
    set_req(4'b1000);
    grant_bus(0);
    run_xfer(3, 3, 3, 0, 0, 1);
    set_req(4'b0000);

    // Demand write on ch2, DREQ dropped during the 2nd word
    modeSel = 8'b01_00_01_01;
    modeXfer = 8'b00_01_00_00;
    set_req(4'b0100);
    grant_bus(1);
    run_xfer(2, 2, 0, 2, 1, 0);

    // Masked request never raises HRQ
    maskReg = 4'b0001;
    set_req(4'b0001);
    idle_watch(4, "masked_req");
    maskReg = 4'b0000;
    set_req(4'b0000);

    // Block on ch0: mask toggle mid-transfer, then disable toggle
    modeSel = 8'b01_01_01_10;
    modeXfer = 8'b00_00_00_01;
    set_req(4'b0001);
    grant_bus(0);
    run_xfer(0, 2, 0, 2, 2, 0);
    idle_watch(3, "mask_stop");
    maskReg = 4'b0000;
    grant_bus(0);
    run_xfer(0, 1, 0, 1, 3, 0);
    idle_watch(3, "disable_stop");
    cmdCtrlDisable = 1'b0;
    set_req(4'b0000);

    // External EOP during block on ch1 terminates at that word
    modeSel = 8'b01_01_10_01;
    modeXfer = 8'b00_00_10_00;
    set_req(4'b0010);
    grant_bus(0);
    run_xfer(1, 2, 0, 2, 5, 1);
    set_req(4'b0000);

    // HLDA dropped in S2: straight to SI, no update pulse
    modeSel = 8'b01_01_01_01;
    modeXfer = 8'b00_00_00_10;
    set_req(4'b0001);
    grant_bus(1);
    @(negedge CLK) check("hdrop_s1", bus_now(), bus_exp(1, 0, 2, 0, 0));
    @(negedge CLK) check("hdrop_s2", bus_now(), bus_exp(2, 0, 2, 0, 0));
    HLDA = 1'b0;
    set_req(4'b0000);
    @(negedge CLK) check("hdrop_idle", bus_now(), bus_exp(0, 0, 2, 0, 0));
    ptr_m = 1;

    // Status read coinciding with TC on ch1
    modeXfer = 8'b00_00_01_00;
    set_req(4'b0010);
    grant_bus(0);
    run_xfer(1, 1, 1, 1, 4, 1);
    set_req(4'b0000);

    // Randomized services
    for (int it = 0; it < 24; it++) begin
      cmdRotatingPriority = 1'($urandom_range(0, 1));
      cmdDreqActiveLow    = 1'($urandom_range(0, 1));
      cmdDackActiveHigh   = 1'($urandom_range(0, 1));
      modeXfer = 8'($urandom);
      modeSel  = 8'($urandom);
      do begin
        r = 4'($urandom_range(1, 15));
        m = 4'($urandom_range(0, 15));
      end while ((r & ~m) == 4'b0000);
      maskReg = m;
      set_req(r);
      ch = pick(r & ~m, cmdRotatingPriority);
      md = $urandom_range(0, 3);
      modeSel[2*ch +: 2] = 2'(md);
      grant_bus($urandom_range(0, 3));
      if (md == 0) begin
        n = $urandom_range(1, 3);
        run_xfer(ch, n, 0, n, 1, 0);
      end else if (md == 2) begin
        n = $urandom_range(1, 3);
        run_xfer(ch, n, n, 0, 0, 1);
      end else begin
        tcw = $urandom_range(0, 1);
        run_xfer(ch, 1, tcw, 0, 0, tcw != 0);
      end
      set_req(4'b0000);
      maskReg = 4'b0000;
    end

    // Asynchronous reset while in S3
    cmdDreqActiveLow = 1'b0;
    cmdDackActiveHigh = 1'b0;
    cmdRotatingPriority = 1'b0;
    modeSel = 8'b01_01_01_01;
    modeXfer = 8'b00_00_00_10;
    set_req(4'b0001);
    grant_bus(0);
    @(negedge CLK) check("rst_s1", bus_now(), bus_exp(1, 0, 2, 0, 0));
    @(negedge CLK) check("rst_s2", bus_now(), bus_exp(2, 0, 2, 0, 0));
    @(negedge CLK) check("rst_s3", bus_now(), bus_exp(3, 0, 2, 0, 0));
    RESET_N = 1'b0;
    #1;
    check("rst_async_bus", bus_now(), bus_exp(0, 0, 0, 0, 0));
    check("rst_async_tc", tcStatus, 0);
    HLDA = 1'b0;
    set_req(4'b0000);
    @(negedge CLK);
    RESET_N = 1'b1;
    idle_watch(2, "post_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_timing_control.md
# dma_timing_control

Timing-and-control sequencer for the four-channel 8237-style DMA controller. It samples channel requests, arbitrates by fixed or rotating priority, negotiates the bus with the CPU via HRQ/HLDA, and runs the S1–S4 transfer state sequence. It drives DACK, AEN, ADSTB, the memory/IO strobes and EOP_N. It also pulses the address/word-count datapath once per transfer. It sits between the register file (command, mode, mask) and the external bus.

## Interface
- NUM_CH, 4, number of channels; only 4 is supported.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  4  channel requests, raw pin level.
- HLDA  in  1  hold acknowledge from CPU.
- EOP_N_in  in  1  external end-of-process, active-low.
- cmdCtrlDisable  in  1  command bit 2; blocks new arbitration.
- cmdRotatingPriority  in  1  command bit 4; 0 = fixed priority, 1 = rotating.
- cmdDreqActiveLow  in  1  command bit 6.
- cmdDackActiveHigh  in  1  command bit 7.
- maskReg  in  4  1 = channel masked.
- modeXfer  in  8  2 bits per channel: 00 verify, 01 write (IO→mem), 10 read (mem→IO).
- modeSel  in  8  2 bits per channel: 00 demand, 01 single, 10 block, 11 cascade (handled as single).
- tcReached  in  1  datapath flag: the active channel's current word count is 0.
- readStatusClear  in  1  status register read strobe; clears tcStatus.
- HRQ  out  1  hold request.
- DACK  out  4  channel acknowledges, polarity set by cmdDackActiveHigh.
- AEN, ADSTB  out  1  address enable and upper-address strobe.
- MEMR_N, MEMW_N, IOR_N, IOW_N  out  1  bus strobes, active-low.
- EOP_N_out  out  1  terminal-count pulse, active-low.
- addrWordUpdate  out  1  one-cycle pulse; datapath increments or decrements the address and decrements the word count.
- activeChannel  out  2  channel being serviced.
- tcStatus  out  4  sticky per-channel TC bits.

## Operation
- Effective request: req = (DREQ ^ {4{cmdDreqActiveLow}}) & ~maskReg.
- States and transitions:
  - SI → S0 when |req and !cmdCtrlDisable.
  - S0 → S1 when HLDA=1. The arbiter winner is latched into activeChannel. If req clears first, S0 → SI.
  - S1 → S2 → S3 → S4, one cycle each.
- S4 exit:
  - Terminal (tcReached, or EOP_N_in sampled low in S2–S4) → SI. tcStatus[ch] is set.
  - Otherwise single → SI.
  - Block → S1.
  - Demand → S1 if req[ch] is still active, else SI.
- Outputs by state:
  - HRQ=1 in S0–S4.
  - AEN=1 in S1–S4.
  - ADSTB=1 in S1 only.
  - DACK[ch] active in S2–S4.
- Strobes:
  - Read transfer: MEMR_N low S2–S4, IOW_N low S3–S4.
  - Write transfer: IOR_N low S2–S4, MEMW_N low S3–S4.
  - Verify transfer: no strobes.
- addrWordUpdate=1 in S4.
- EOP_N_out=0 in S4 when tcReached=1.
- Rotating priority: when a service exits to SI, the serviced channel becomes lowest priority. Fixed priority: ch0 highest.
- HLDA falling in S1–S4 → SI next edge. All strobes are released and no addrWordUpdate is issued.
- Mask or cmdCtrlDisable changes affect arbitration only. An in-flight transfer completes through S4. A masked channel in demand or block mode then exits to SI.
- readStatusClear coinciding with a TC set: the set wins for that bit, and the other bits clear.

## Timing
- Reset values:
  - State SI.
  - HRQ, AEN, ADSTB, addrWordUpdate = 0.
  - All strobes and EOP_N_out = 1.
  - activeChannel = 0, tcStatus = 0, rotation pointer = ch0 highest.
  - DACK at its inactive level, ~cmdDackActiveHigh.
- All outputs are decoded from registered state. No input-to-output combinational path exists except DACK polarity.
- Request sampled in SI → HRQ high 1 cycle later.
- HLDA sampled high in S0 → AEN/ADSTB high the next cycle.
- A single transfer holds the bus for 4 cycles (S1–S4). HRQ drops the cycle after S4.
- Block transfer of N words: 4N cycles of continuous HRQ.

## Structure
- dma_pkg holds:
  - dmaState_t enum {SI, S0, S1, S2, S3, S4}.
  - xferType_t enum {VERIFY, WRITE, READ}.
  - modeSel_t enum {DEMAND, SINGLE, BLOCK, CASCADE}.
  - Register bit-position constants.
- Sub-module dma_priority_arbiter: takes req[3:0], the rotating flag and the rotation pointer; returns the grant index and a valid signal. It also owns the pointer update.

## Test plan
- Fixed priority: DREQ=0b1010, HLDA returned 2 cycles after HRQ → activeChannel=1, DACK[1] active in S2–S4, exactly one addrWordUpdate.
- Rotating priority: ch0 and ch2 both requesting, single mode → services alternate ch0, ch2, ch0.
- Block read on ch3, tcReached asserted on the 3rd S4 → 12 bus cycles, EOP_N_out low in the final S4, tcStatus=0b1000, then SI.
- Demand write on ch2, DREQ dropped during the 2nd transfer → exit to SI after that S4. Strobe order is IOR_N then MEMW_N.
- Masked request (maskReg=0b0001, DREQ=0b0001) → HRQ stays 0. A mask or cmdCtrlDisable toggle during an in-flight block transfer → the current S4 completes, then SI.
- Edge cases:
  - RESET_N low in S3 → all outputs return to reset values asynchronously.
  - HLDA drop in S2 → SI with no update.
  - readStatusClear together with TC on ch1 → tcStatus[1]=1.
